// File: rtl/chip8_mem_arbiter.sv
// Shares the single CHIP-8 memory port between CPU and graphics engine, with a
// gfx-streak limit for CPU fairness and write protection of the low interpreter area.
module chip8_mem_arbiter #(
  parameter int                 ADDR_W     = 14,
  parameter int                 DATA_W     = 8,
  parameter int                 MAX_STREAK = 4,
  parameter logic [ADDR_W-1:0]  PROT_TOP   = 14'h200
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              gfx_req,
  input  logic [ADDR_W-1:0] gfx_addr,
  output logic              gfx_ack,
  output logic              gfx_rvalid,
  output logic [DATA_W-1:0] gfx_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              wr_fault
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  logic [3:0] streak_q, streak_d;
  logic       cpu_rv_q, cpu_rv_d;
  logic       gfx_rv_q, gfx_rv_d;
  logic       fault_q, fault_d;
  logic       cpu_win, gnt_cpu, gnt_gfx, prot_hit;

  always_comb begin
    // gfx normally wins a collision; the CPU takes over once the streak is exhausted
    cpu_win  = cpu_req & (~gfx_req | (streak_q == STREAK_MAX));
    gnt_cpu  = reset_n & cpu_win;
    gnt_gfx  = reset_n & gfx_req & ~cpu_win;
    prot_hit = cpu_addr < PROT_TOP;

    cpu_ack  = gnt_cpu;
    gfx_ack  = gnt_gfx;
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_din  = '0;
    if (gnt_cpu) begin
      mem_addr = cpu_addr;
      if (cpu_we) begin
        mem_din = cpu_wdata;
        mem_we  = ~prot_hit;
      end
    end else if (gnt_gfx) begin
      mem_addr = gfx_addr;
    end

    streak_d = streak_q;
    if (!cpu_req || gnt_cpu)
      streak_d = '0;
    else if (gnt_gfx && streak_q != STREAK_MAX)
      streak_d = streak_q + 4'd1;

    cpu_rv_d = gnt_cpu & ~cpu_we;
    gfx_rv_d = gnt_gfx;
    fault_d  = fault_q | (gnt_cpu & cpu_we & prot_hit);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      streak_q <= '0;
      cpu_rv_q <= 1'b0;
      gfx_rv_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      streak_q <= streak_d;
      cpu_rv_q <= cpu_rv_d;
      gfx_rv_q <= gfx_rv_d;
      fault_q  <= fault_d;
    end
  end

  // Read tags are also masked while reset is held so a read in flight is dropped.
  assign cpu_rvalid = cpu_rv_q & reset_n;
  assign gfx_rvalid = gfx_rv_q & reset_n;
  assign cpu_rdata  = cpu_rvalid ? mem_dout : '0;
  assign gfx_rdata  = gfx_rvalid ? mem_dout : '0;
  assign wr_fault   = fault_q;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed bench for chip8_mem_arbiter with a behavioural 16 KiB synchronous memory.
module tb_chip8_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we, gfx_req;
  logic [13:0] cpu_addr, gfx_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack, cpu_rvalid, gfx_ack, gfx_rvalid, mem_we, wr_fault;
  logic [7:0]  cpu_rdata, gfx_rdata, mem_din, mem_dout;
  logic [13:0] mem_addr;
  logic [7:0]  mem [0:16383];
  int          nchk = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  chip8_mem_arbiter #(.ADDR_W(14), .DATA_W(8), .MAX_STREAK(4), .PROT_TOP(14'h200)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .gfx_req(gfx_req), .gfx_addr(gfx_addr), .gfx_ack(gfx_ack),
    .gfx_rvalid(gfx_rvalid), .gfx_rdata(gfx_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
    .wr_fault(wr_fault)
  );

  function automatic logic [7:0] init_val(int a);
    logic [7:0] font [0:4];
    font = '{8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0};
    if (a < 5) return font[a];
    return 8'((a * 37 + 11) ^ (a >> 8));
  endfunction

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    gfx_req = 0; gfx_addr = '0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = init_val(i);
    reset_n = 0; idle();

    // reset: requests ignored, outputs quiet
    tick(); cpu_req = 1; cpu_addr = 14'h123; gfx_req = 1; gfx_addr = 14'h234; #1;
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_gfx_ack", gfx_ack, 0);
    chk("rst_mem_addr", mem_addr, 0);
    tick(); #1;
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_gfx_rvalid", gfx_rvalid, 0);
    chk("rst_wr_fault", wr_fault, 0);
    tick(); reset_n = 1; idle(); #1;

    // lone CPU read of font byte 0
    tick(); cpu_req = 1; cpu_addr = 14'h000; #1;
    chk("rd0_ack", cpu_ack, 1);
    chk("rd0_mem_addr", mem_addr, 14'h000);
    chk("rd0_mem_we", mem_we, 0);
    tick(); idle(); #1;
    chk("rd0_rvalid", cpu_rvalid, 1);
    chk("rd0_rdata", cpu_rdata, 8'hF0);
    tick(); #1;
    chk("rd0_rvalid_n2", cpu_rvalid, 0);
    chk("rd0_rdata_n2", cpu_rdata, 0);

    // both requesting continuously: 4 gfx grants then 1 CPU grant, repeating
    for (int k = 0; k < 11; k++) begin
      tick();
      if (k < 10) begin
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h001;
        gfx_req = 1; gfx_addr = 14'h200;
      end else idle();
      #1;
      if (k < 10) begin
        chk($sformatf("arb_gfx_ack%0d", k), gfx_ack, (k % 5) != 4);
        chk($sformatf("arb_cpu_ack%0d", k), cpu_ack, (k % 5) == 4);
        chk($sformatf("arb_mem_addr%0d", k), mem_addr, ((k % 5) == 4) ? 14'h001 : 14'h200);
      end
      chk($sformatf("arb_gfx_rv%0d", k), gfx_rvalid, k > 0 && ((k - 1) % 5) != 4);
      chk($sformatf("arb_cpu_rv%0d", k), cpu_rvalid, k > 0 && ((k - 1) % 5) == 4);
      if (k > 0 && ((k - 1) % 5) == 4) chk($sformatf("arb_cpu_rd%0d", k), cpu_rdata, 8'h90);
      if (k > 0 && ((k - 1) % 5) != 4) chk($sformatf("arb_gfx_rd%0d", k), gfx_rdata, init_val(14'h200));
    end

    // unprotected write then read-back
    tick(); cpu_req = 1; cpu_we = 1; cpu_addr = 14'h300; cpu_wdata = 8'hA5; #1;
    chk("wr_ack", cpu_ack, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_din", mem_din, 8'hA5);
    chk("wr_mem_addr", mem_addr, 14'h300);
    tick(); cpu_we = 0; cpu_wdata = 0; #1;
    chk("wr_rd_ack", cpu_ack, 1);
    chk("wr_no_rvalid", cpu_rvalid, 0);
    tick(); idle(); #1;
    chk("wr_rd_rvalid", cpu_rvalid, 1);
    chk("wr_rd_data", cpu_rdata, 8'hA5);
    chk("wr_no_fault", wr_fault, 0);

    // protected write: acked, suppressed, sticky fault
    tick(); cpu_req = 1; cpu_we = 1; cpu_addr = 14'h1FF; cpu_wdata = 8'h55; #1;
    chk("pw_ack", cpu_ack, 1);
    chk("pw_mem_we", mem_we, 0);
    chk("pw_fault_pre", wr_fault, 0);
    tick(); cpu_we = 0; cpu_wdata = 0; #1;
    chk("pw_fault", wr_fault, 1);
    tick(); idle(); #1;
    chk("pw_rd_rvalid", cpu_rvalid, 1);
    chk("pw_rd_data", cpu_rdata, init_val(14'h1FF));
    chk("pw_fault_sticky", wr_fault, 1);

    // gfx burst 0x200..0x20F
    for (int i = 0; i < 17; i++) begin
      tick();
      gfx_req = (i < 16); gfx_addr = 14'(14'h200 + i); #1;
      chk($sformatf("gb_ack%0d", i), gfx_ack, i < 16);
      chk($sformatf("gb_rv%0d", i), gfx_rvalid, i > 0);
      if (i > 0) chk($sformatf("gb_rd%0d", i), gfx_rdata, init_val(14'h200 + i - 1));
    end

    // reset right after a CPU read ack
    tick(); idle(); cpu_req = 1; cpu_addr = 14'h000; #1;
    chk("rr_ack", cpu_ack, 1);
    tick(); reset_n = 0; cpu_addr = 14'h002; #1;
    chk("rr_ack_in_rst", cpu_ack, 0);
    chk("rr_mem_we", mem_we, 0);
    chk("rr_mem_addr", mem_addr, 0);
    chk("rr_rvalid", cpu_rvalid, 0);
    chk("rr_rdata", cpu_rdata, 0);
    tick(); #1;
    chk("rr_fault_clr", wr_fault, 0);
    chk("rr_rvalid2", cpu_rvalid, 0);
    tick(); reset_n = 1; #1;
    chk("rr_resume_ack", cpu_ack, 1);
    tick(); idle(); #1;
    chk("rr_resume_rvalid", cpu_rvalid, 1);
    chk("rr_resume_rdata", cpu_rdata, 8'h90);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
